// File: rtl/mat_scan_controller.sv
// mat_scan_controller
//   Frame sequencer for the corner-detect matrix read. For each reference pixel it
//   issues N_ADJ circle-neighbour read indices, replays them READ_LAT cycles later as
//   register-file writes, then pulses matReaden once all writes for that pixel landed.
//   Optional build macro: MAT_BORDER_SKIP_EN -- visit only pixels whose whole circle
//   of RADIUS lies inside the image (adds a column counter). Default: full linear scan.
module mat_scan_controller #(
  parameter int IMG_W    = 160,
  parameter int IMG_H    = 135,
  parameter int N_ADJ    = 16,
  parameter int IDX_W    = 4,
  parameter int READ_LAT = 2,
  parameter int ADDR_W   = 15,
  parameter int RADIUS   = 3
) (
  input  logic              clock,
  input  logic              nReset,
  input  logic              start,
  input  logic              stall,
  output logic [ADDR_W-1:0] refAddr,
  output logic [IDX_W-1:0]  adjNumber,
  output logic              adjValid,
  output logic [IDX_W-1:0]  regAddr,
  output logic              regWe,
  output logic              matReaden,
  output logic              busy,
  output logic              frameDone
);

  // Elaboration-time sanity of the parameter set.
  if ((1 << IDX_W) != N_ADJ) begin : gBadIdx
    $error("N_ADJ must equal 2**IDX_W");
  end
  if (READ_LAT < 1 || READ_LAT > 4) begin : gBadLat
    $error("READ_LAT must be 1..4");
  end
  if (RADIUS < 1 || 2 * RADIUS >= IMG_W || 2 * RADIUS >= IMG_H) begin : gBadRad
    $error("RADIUS leaves no interior pixels");
  end
  if ((IMG_W * IMG_H - 1) >= (1 << ADDR_W)) begin : gBadAddr
    $error("ADDR_W too narrow for the frame");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [IDX_W-1:0] ADJ_LAST   = IDX_W'(N_ADJ - 1);
  localparam logic [2:0]       DRAIN_LAST = 3'(READ_LAT - 1);

`ifdef MAT_BORDER_SKIP_EN
  localparam logic [ADDR_W-1:0] FIRST = ADDR_W'(RADIUS * IMG_W + RADIUS);
  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'((IMG_H - RADIUS) * IMG_W - RADIUS - 1);
  localparam int                COL_W = $clog2(IMG_W);
  localparam logic [COL_W-1:0]  COL_FIRST = COL_W'(RADIUS);
  localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(IMG_W - RADIUS - 1);
  // Jump from the last interior column to the first interior column of the next row.
  localparam logic [ADDR_W-1:0] ROW_JUMP  = ADDR_W'(2 * RADIUS + 1);
`else
  localparam logic [ADDR_W-1:0] FIRST = '0;
  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(IMG_W * IMG_H - 1);
`endif

  state_t                         state, stateNext;
  logic [IDX_W-1:0]               adjCnt;
  logic [2:0]                     drainCnt;
  logic [ADDR_W-1:0]              nextAddr;
  logic                           isLast;
  logic [READ_LAT-1:0]            vldPipe;
  logic [READ_LAT-1:0][IDX_W-1:0] idxPipe;

  assign isLast = (refAddr == LAST);

  // State register; stall is folded into stateNext so the FSM simply holds.
  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) state <= IDLE;
    else         state <= stateNext;
  end

  // Next-state and per-state outputs. Pulses stretch naturally under stall
  // because the FSM holds in DONE.
  always_comb begin
    stateNext = state;
    adjValid  = 1'b0;
    matReaden = 1'b0;
    frameDone = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) stateNext = ISSUE;
      end
      ISSUE: begin
        adjValid = 1'b1;
        if (adjCnt == ADJ_LAST) stateNext = DRAIN;
      end
      DRAIN: begin
        if (drainCnt == DRAIN_LAST) stateNext = DONE;
      end
      DONE: begin
        matReaden = 1'b1;
        frameDone = isLast;
        stateNext = isLast ? IDLE : ISSUE;
      end
      default: stateNext = IDLE;
    endcase
    if (stall) stateNext = state;
  end

  // adjCnt is 0 outside ISSUE (it wraps after N_ADJ-1), so adjNumber idles at 0.
  assign adjNumber = adjValid ? adjCnt : '0;

  // Neighbour index counter and the drain timer that waits for the last write.
  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      adjCnt   <= '0;
      drainCnt <= '0;
    end else if (!stall) begin
      if (state == ISSUE) adjCnt <= adjCnt + IDX_W'(1);
      if (state == DRAIN) drainCnt <= drainCnt + 3'd1;
      else                drainCnt <= '0;
    end
  end

`ifdef MAT_BORDER_SKIP_EN
  logic [COL_W-1:0] colCnt;

  assign nextAddr = (colCnt == COL_LAST) ? refAddr + ROW_JUMP : refAddr + ADDR_W'(1);

  // Column of refAddr, used to spot the end of an interior row.
  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      colCnt <= COL_FIRST;
    end else if (!stall && state == DONE) begin
      if (isLast || colCnt == COL_LAST) colCnt <= COL_FIRST;
      else                              colCnt <= colCnt + COL_W'(1);
    end
  end
`else
  assign nextAddr = refAddr + ADDR_W'(1);
`endif

  // Reference pixel advances as its matReaden cycle retires; wraps to FIRST after LAST.
  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      refAddr <= FIRST;
    end else if (!stall && state == DONE) begin
      refAddr <= isLast ? FIRST : nextAddr;
    end
  end

  // Read-latency delay line: writes replay the read requests READ_LAT cycles later.
  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      vldPipe <= '0;
      idxPipe <= '0;
    end else if (!stall) begin
      vldPipe[0] <= adjValid;
      idxPipe[0] <= adjNumber;
      for (int i = 1; i < READ_LAT; i++) begin
        vldPipe[i] <= vldPipe[i-1];
        idxPipe[i] <= idxPipe[i-1];
      end
    end
  end

  assign regWe   = vldPipe[READ_LAT-1];
  assign regAddr = idxPipe[READ_LAT-1];

endmodule

// File: tb/tb_mat_scan_controller.sv
// tb_mat_scan_controller
//   Scoreboard bench on a shrunken image. Each start pushes the full expected frame
//   (read indices, write indices, matReaden addresses) keyed by unstalled-cycle count;
//   the per-cycle monitor pops and compares. Also runs with MAT_BORDER_SKIP_EN.
module tb_mat_scan_controller;

  localparam int W    = 8;
  localparam int H    = 6;
  localparam int R    = 1;
  localparam int N    = 16;
  localparam int IW   = 4;
  localparam int LAT  = 2;
  localparam int AW   = 15;
  localparam int P    = N + LAT + 1;

  typedef struct { int cyc; int val; int last; } ev_t;

  logic          clock = 1'b0;
  logic          nReset;
  logic          start;
  logic          stall;
  logic [AW-1:0] refAddr;
  logic [IW-1:0] adjNumber;
  logic          adjValid;
  logic [IW-1:0] regAddr;
  logic          regWe;
  logic          matReaden;
  logic          busy;
  logic          frameDone;

  mat_scan_controller #(
    .IMG_W(W), .IMG_H(H), .N_ADJ(N), .IDX_W(IW), .READ_LAT(LAT), .ADDR_W(AW), .RADIUS(R)
  ) dut (
    .clock(clock), .nReset(nReset), .start(start), .stall(stall),
    .refAddr(refAddr), .adjNumber(adjNumber), .adjValid(adjValid),
    .regAddr(regAddr), .regWe(regWe), .matReaden(matReaden),
    .busy(busy), .frameDone(frameDone)
  );

  always #5 clock = ~clock;

  int  nChecks = 0;
  int  nErrors = 0;
  int  cyc     = 0;   // every cycle
  int  ecyc    = 0;   // unstalled cycles only
  int  stallLo = -1;
  int  stallHi = -2;
  int  matCyc  = -1;
  int  addrList[$];
  ev_t adjQ[$];
  ev_t regQ[$];
  ev_t matQ[$];

  task automatic chk(input string tag, input int got, input int exp);
    nChecks++;
    if (got !== exp) begin
      nErrors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Expected trace of a whole frame whose start is sampled at the end of unstalled cycle base.
  task automatic pushFrame(input int base);
    ev_t ev;
    for (int p = 0; p < addrList.size(); p++) begin
      int b;
      b = base + p * P;
      for (int i = 0; i < N; i++) begin
        ev.cyc = b + 1 + i;       ev.val = i; ev.last = 0; adjQ.push_back(ev);
        ev.cyc = b + 1 + i + LAT; ev.val = i; ev.last = 0; regQ.push_back(ev);
      end
      ev.cyc  = b + N + LAT + 1;
      ev.val  = addrList[p];
      ev.last = (p == addrList.size() - 1) ? 1 : 0;
      matQ.push_back(ev);
    end
  endtask

  task automatic monitor();
    bit e;
    e = 1'b0;
    if (adjQ.size() > 0) e = (adjQ[0].cyc == ecyc);
    chk("adjValid", adjValid, e);
    if (e) begin chk("adjNumber", adjNumber, adjQ[0].val); void'(adjQ.pop_front()); end
    e = 1'b0;
    if (regQ.size() > 0) e = (regQ[0].cyc == ecyc);
    chk("regWe", regWe, e);
    if (e) begin chk("regAddr", regAddr, regQ[0].val); void'(regQ.pop_front()); end
    e = 1'b0;
    if (matQ.size() > 0) e = (matQ[0].cyc == ecyc);
    chk("matReaden", matReaden, e);
    if (e) begin
      chk("refAddr", refAddr, matQ[0].val);
      chk("frameDone", frameDone, matQ[0].last);
      if (matCyc < 0) matCyc = cyc;
      void'(matQ.pop_front());
    end else begin
      chk("frameDone", frameDone, 0);
    end
  endtask

  // One clock: sample #1 after the edge, set stall for the cycle now running.
  task automatic step();
    @(posedge clock);
    #1;
    cyc++;
    stall = (cyc >= stallLo && cyc <= stallHi);
    if (!stall) begin
      ecyc++;
      monitor();
    end
  endtask

  task automatic kick(output int s);
    s      = cyc;
    matCyc = -1;
    start  = 1'b1;
    pushFrame(ecyc);
    step();
    start  = 1'b0;
  endtask

  task automatic chkIdle(input string tag);
    chk({tag, ".busy"},    busy, 0);
    chk({tag, ".refAddr"}, refAddr, addrList[0]);
    chk({tag, ".adjValid"}, adjValid, 0);
  endtask

  initial begin
    int s;
`ifdef MAT_BORDER_SKIP_EN
    for (int r = R; r < H - R; r++)
      for (int c = R; c < W - R; c++) addrList.push_back(r * W + c);
`else
    for (int a = 0; a < W * H; a++) addrList.push_back(a);
`endif
    nReset = 1'b0; start = 1'b0; stall = 1'b0;
    repeat (3) step();
    chk("rst.adjValid", adjValid, 0);
    chk("rst.adjNumber", adjNumber, 0);
    chk("rst.regWe", regWe, 0);
    chk("rst.regAddr", regAddr, 0);
    chk("rst.matReaden", matReaden, 0);
    chk("rst.frameDone", frameDone, 0);
    chk("rst.busy", busy, 0);
    chk("rst.refAddr", refAddr, addrList[0]);
    nReset = 1'b1;
    repeat (2) step();

    // Frame 1: basic timing, start while busy, start in the frameDone cycle.
    kick(s);
    for (int n = 0; n < addrList.size() * P + 20 && matQ.size() > 0; n++) begin
      step();
      start = 1'b0;
      if (cyc == s + 5) begin chk("f1.busy", busy, 1); start = 1'b1; end
      if (cyc == s + P + 1) chk("f1.secondAddr", refAddr, addrList[1]);
      if (frameDone) start = 1'b1;
    end
    chk("f1.drained", matQ.size(), 0);
    chk("f1.matCycle", matCyc - s, N + LAT + 1);
    step();
    start = 1'b0;
    chkIdle("f1.end");
    repeat (4) step();
    chkIdle("f1.quiet");

    // Frame 2: stall held over cycles 5..9 of the first pixel.
    kick(s);
    stallLo = s + 5;
    stallHi = s + 9;
    for (int n = 0; n < addrList.size() * P + 40 && matQ.size() > 0; n++) begin
      step();
      if (cyc == s + 7) begin
        chk("f2.stallAdj", adjNumber, 4);
        chk("f2.stallVld", adjValid, 1);
      end
    end
    stallLo = -1; stallHi = -2;
    chk("f2.drained", matQ.size(), 0);
    chk("f2.matCycle", matCyc - s, N + LAT + 6);
    step();
    chkIdle("f2.end");

    // Frame 3: asynchronous reset in the middle of ISSUE.
    kick(s);
    while (cyc < s + 10) step();
    #2 nReset = 1'b0;
    #1;
    chk("rstA.adjValid", adjValid, 0);
    chk("rstA.adjNumber", adjNumber, 0);
    chk("rstA.regWe", regWe, 0);
    chk("rstA.busy", busy, 0);
    chk("rstA.matReaden", matReaden, 0);
    chk("rstA.refAddr", refAddr, addrList[0]);
    adjQ.delete(); regQ.delete(); matQ.delete();
    repeat (3) step();
    nReset = 1'b1;
    repeat (30) step();
    chkIdle("rstA.after");

    // Frame 4: clean restart after reset.
    kick(s);
    for (int n = 0; n < addrList.size() * P + 20 && matQ.size() > 0; n++) step();
    chk("f4.drained", matQ.size(), 0);
    chk("f4.matCycle", matCyc - s, N + LAT + 1);
    step();
    chkIdle("f4.end");
    chk("sb.adjEmpty", adjQ.size(), 0);
    chk("sb.regEmpty", regQ.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
